ahb_master_mux: RTL and testbench

- Address/control and write-data multiplexer directly downstream of the AHB arbiter.
- Consumes HMASTER and HMASTLOCK from the arbiter.
- Routes the granted master's address-phase signals onto the shared bus. Routes write data using a data-phase master register that advances only on HREADY, per AMBA 2 AHB pipelining.
- Also provides a completed-transfer counter for bus monitoring.

---
 rtl/ahb_master_mux.sv | 133 +++++++++++++
 tb/tb_ahb_master_mux.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_mux.sv
// ---------------------------------------------------------------------------
// ahb_master_mux
//
// Sits directly downstream of the AHB arbiter.  The granted master's
// address-phase signals (HADDR/HTRANS/HWRITE/HSIZE/HBURST) are selected
// combinationally by HMASTER.  A data-phase register, advanced only when
// HREADY=1, remembers which master (and lock state) owns the data phase.
// That registered index then steers the write-data mux.  A 16-bit counter
// tallies every completed NONSEQ/SEQ data phase for bus monitoring.
//
// Ports:
//   HCLK, HRESET        bus clock, asynchronous active-high reset
//   HMASTER, HMASTLOCK  address-phase master index and lock from the arbiter
//   HREADY              1 = the current data phase completes this cycle
//   HADDRx..HWDATAx     per-master buses, master m in slice [m*W +: W]
//   HADDR..HBURST       muxed address-phase outputs
//   HWDATA              muxed write data for the current data phase
//   HMASTER_D           data-phase master index
//   HMASTLOCK_D         data-phase lock flag
//   DVALID              current data phase belongs to a NONSEQ/SEQ transfer
//   XFER_CNT            number of completed NONSEQ/SEQ data phases (wraps)
// ---------------------------------------------------------------------------
module ahb_master_mux #(
    parameter int NMASTERS = 16,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [3:0]                   HMASTER,
    input  logic                         HMASTLOCK,
    input  logic                         HREADY,
    input  logic [NMASTERS*ADDR_W-1:0]   HADDRx,
    input  logic [NMASTERS*2-1:0]        HTRANSx,
    input  logic [NMASTERS-1:0]          HWRITEx,
    input  logic [NMASTERS*3-1:0]        HSIZEx,
    input  logic [NMASTERS*3-1:0]        HBURSTx,
    input  logic [NMASTERS*DATA_W-1:0]   HWDATAx,
    output logic [ADDR_W-1:0]            HADDR,
    output logic [1:0]                   HTRANS,
    output logic                         HWRITE,
    output logic [2:0]                   HSIZE,
    output logic [2:0]                   HBURST,
    output logic [DATA_W-1:0]            HWDATA,
    output logic [3:0]                   HMASTER_D,
    output logic                         HMASTLOCK_D,
    output logic                         DVALID,
    output logic [15:0]                  XFER_CNT
);

    localparam logic [1:0] TRANS_IDLE = 2'b00;

    logic [ADDR_W-1:0] w_addrMux;
    logic [1:0]        w_transMux;
    logic              w_writeMux;
    logic [2:0]        w_sizeMux;
    logic [2:0]        w_burstMux;
    logic [DATA_W-1:0] w_wdataMux;

    logic [3:0]        r_masterD;
    logic              r_lockD;
    logic              r_dvalid;
    logic [15:0]       r_xferCnt;

    // Address-phase mux.  A loop of equality compares keeps an index beyond
    // NMASTERS from ever reaching a slice, so such an index yields all zeros
    // (which also makes HTRANS read as IDLE).
    always_comb begin
        w_addrMux  = '0;
        w_transMux = TRANS_IDLE;
        w_writeMux = 1'b0;
        w_sizeMux  = 3'b000;
        w_burstMux = 3'b000;
        for (int m = 0; m < NMASTERS; m++) begin
            if (HMASTER == 4'(m)) begin
                w_addrMux  = HADDRx[m*ADDR_W +: ADDR_W];
                w_transMux = HTRANSx[m*2 +: 2];
                w_writeMux = HWRITEx[m];
                w_sizeMux  = HSIZEx[m*3 +: 3];
                w_burstMux = HBURSTx[m*3 +: 3];
            end
        end
    end

    // Only HTRANS is suppressed during reset so that no slave sees a live
    // transfer; the remaining address-phase signals stay transparent.
    assign HADDR  = w_addrMux;
    assign HTRANS = HRESET ? TRANS_IDLE : w_transMux;
    assign HWRITE = w_writeMux;
    assign HSIZE  = w_sizeMux;
    assign HBURST = w_burstMux;

    // Data-phase register and completed-transfer counter.  Both advance only
    // when HREADY=1, so wait states stretch the current data phase.  On a
    // pipelined edge the counter credits the phase that is finishing (old
    // r_dvalid) while r_dvalid is reloaded for the phase being launched.
    // NONSEQ and SEQ are exactly the transfer types with bit 1 set.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_masterD <= 4'd0;
            r_lockD   <= 1'b0;
            r_dvalid  <= 1'b0;
            r_xferCnt <= 16'd0;
        end else if (HREADY) begin
            r_masterD <= HMASTER;
            r_lockD   <= HMASTLOCK;
            r_dvalid  <= w_transMux[1];
            if (r_dvalid) begin
                r_xferCnt <= r_xferCnt + 16'd1;
            end
        end
    end

    // Write-data mux steered by the registered data-phase owner; gated to
    // zero when the data phase carries no real transfer.
    always_comb begin
        w_wdataMux = '0;
        if (r_dvalid) begin
            for (int m = 0; m < NMASTERS; m++) begin
                if (r_masterD == 4'(m)) begin
                    w_wdataMux = HWDATAx[m*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign HWDATA      = w_wdataMux;
    assign HMASTER_D   = r_masterD;
    assign HMASTLOCK_D = r_lockD;
    assign DVALID      = r_dvalid;
    assign XFER_CNT    = r_xferCnt;

endmodule

// File: tb/tb_ahb_master_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_master_mux
//
// Self-checking bench for ahb_master_mux, built with NMASTERS=8 so that the
// out-of-range indices 8..15 are reachable.  A transaction-level model
// (owner, lock, valid, count of completed phases) is advanced by the tick
// task from the same inputs the DUT sees on each edge.
// ---------------------------------------------------------------------------
module tb_ahb_master_mux;

    localparam int NM = 8;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              HCLK;
    logic              HRESET;
    logic [3:0]        HMASTER;
    logic              HMASTLOCK;
    logic              HREADY;
    logic [NM*AW-1:0]  HADDRx;
    logic [NM*2-1:0]   HTRANSx;
    logic [NM-1:0]     HWRITEx;
    logic [NM*3-1:0]   HSIZEx;
    logic [NM*3-1:0]   HBURSTx;
    logic [NM*DW-1:0]  HWDATAx;
    logic [AW-1:0]     HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [DW-1:0]     HWDATA;
    logic [3:0]        HMASTER_D;
    logic              HMASTLOCK_D;
    logic              DVALID;
    logic [15:0]       XFER_CNT;

    int nCompared;
    int nMismatched;

    // Transaction-level model of the data phase.
    logic [3:0]  mOwner;
    logic        mLock;
    logic        mValid;
    logic [15:0] mCount;

    ahb_master_mux #(.NMASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HMASTER     (HMASTER),
        .HMASTLOCK   (HMASTLOCK),
        .HREADY      (HREADY),
        .HADDRx      (HADDRx),
        .HTRANSx     (HTRANSx),
        .HWRITEx     (HWRITEx),
        .HSIZEx      (HSIZEx),
        .HBURSTx     (HBURSTx),
        .HWDATAx     (HWDATAx),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HWDATA      (HWDATA),
        .HMASTER_D   (HMASTER_D),
        .HMASTLOCK_D (HMASTLOCK_D),
        .DVALID      (DVALID),
        .XFER_CNT    (XFER_CNT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic logic [1:0] transOf(input logic [3:0] m);
        if (m < NM) return HTRANSx[m*2 +: 2];
        return 2'b00;
    endfunction

    function automatic logic [AW-1:0] addrOf(input logic [3:0] m);
        if (m < NM) return HADDRx[m*AW +: AW];
        return '0;
    endfunction

    function automatic logic [DW-1:0] wdataOf(input logic [3:0] m);
        if (m < NM) return HWDATAx[m*DW +: DW];
        return '0;
    endfunction

    function automatic logic [DW-1:0] expWdata();
        return mValid ? wdataOf(mOwner) : '0;
    endfunction

    // Advance the model with the inputs present before the edge, then move
    // to one time unit after the rising edge.
    task automatic tick();
        if (!HRESET && HREADY) begin
            if (mValid) mCount = mCount + 16'd1;
            mOwner = HMASTER;
            mLock  = HMASTLOCK;
            mValid = (transOf(HMASTER) == 2'b10) || (transOf(HMASTER) == 2'b11);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic modelClear();
        mOwner = 4'd0;
        mLock  = 1'b0;
        mValid = 1'b0;
        mCount = 16'd0;
    endtask

    task automatic setMaster(input int m, input logic [1:0] tr, input logic [31:0] addr);
        HTRANSx[m*2 +: 2]  = tr;
        HADDRx[m*AW +: AW] = addr;
        HWDATAx[m*DW +: DW] = $urandom;
    endtask

    task automatic allIdle();
        HTRANSx = '0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        modelClear();
        HMASTER = 4'd0;
        setMaster(0, 2'b10, 32'h0000_0040);
        #1;
        nCompared++;
        if (HTRANS !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL reset_htrans actual=%b required=00", HTRANS);
        end
        nCompared++;
        if (HWDATA !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_hwdata actual=%h required=0", HWDATA);
        end
        nCompared++;
        if (XFER_CNT !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_cnt actual=%0d required=0", XFER_CNT);
        end
        tick();
        allIdle();
        HRESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nCompared++;
            if (XFER_CNT !== 16'd0 || DVALID !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL idle_cnt cycle=%0d actual=%0d/%b required=0/0", i, XFER_CNT, DVALID);
            end
        end
    endtask

    task automatic test_handover();
        logic [15:0] c0;
        logic [31:0] w3, w5;
        allIdle();
        HREADY = 1'b1;
        tick();
        c0 = XFER_CNT;
        HMASTER = 4'd3;
        setMaster(3, 2'b10, 32'h0000_1000);
        w3 = HWDATAx[3*DW +: DW];
        #1;
        nCompared++;
        if (HADDR !== 32'h1000 || HTRANS !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL ho_addr3 actual=%h/%b required=1000/10", HADDR, HTRANS);
        end
        tick();
        HMASTER = 4'd5;
        setMaster(5, 2'b10, 32'h0000_2000);
        w5 = HWDATAx[5*DW +: DW];
        #1;
        nCompared++;
        if (HADDR !== 32'h2000 || HMASTER_D !== 4'd3 || HWDATA !== w3) begin
            nMismatched++;
            $display("[TB] FAIL ho_phase3 actual=%h/%0d/%h required=2000/3/%h", HADDR, HMASTER_D, HWDATA, w3);
        end
        tick();
        HMASTER = 4'd0;
        allIdle();
        #1;
        nCompared++;
        if (HMASTER_D !== 4'd5 || HWDATA !== w5 || XFER_CNT !== c0 + 16'd1) begin
            nMismatched++;
            $display("[TB] FAIL ho_phase5 actual=%0d/%h/%0d required=5/%h/%0d", HMASTER_D, HWDATA, XFER_CNT, w5, c0 + 16'd1);
        end
        tick();
        nCompared++;
        if (XFER_CNT !== c0 + 16'd2 || XFER_CNT !== mCount) begin
            nMismatched++;
            $display("[TB] FAIL ho_count actual=%0d required=%0d", XFER_CNT, c0 + 16'd2);
        end
    endtask

    task automatic test_wait_states();
        logic [15:0] c0;
        logic [31:0] w2;
        HREADY = 1'b1;
        HMASTER = 4'd2;
        setMaster(2, 2'b10, 32'h0000_3000);
        w2 = HWDATAx[2*DW +: DW];
        tick();
        c0 = XFER_CNT;
        HREADY = 1'b0;
        HMASTER = 4'd7;
        setMaster(7, 2'b10, 32'h0000_7700);
        for (int i = 0; i < 3; i++) begin
            #1;
            nCompared++;
            if (HADDR !== 32'h7700 || HMASTER_D !== 4'd2 || HWDATA !== w2 || XFER_CNT !== c0) begin
                nMismatched++;
                $display("[TB] FAIL wait_hold cycle=%0d actual=%h/%0d/%h/%0d required=7700/2/%h/%0d",
                         i, HADDR, HMASTER_D, HWDATA, XFER_CNT, w2, c0);
            end
            tick();
        end
        HREADY = 1'b1;
        tick();
        nCompared++;
        if (XFER_CNT !== c0 + 16'd1 || HMASTER_D !== 4'd7) begin
            nMismatched++;
            $display("[TB] FAIL wait_release actual=%0d/%0d required=%0d/7", XFER_CNT, HMASTER_D, c0 + 16'd1);
        end
        allIdle();
        tick();
    endtask

    task automatic test_busy_filter();
        logic [15:0] c0;
        logic [1:0]  seqT [3];
        logic        expV [3];
        seqT[0] = 2'b10; seqT[1] = 2'b01; seqT[2] = 2'b11;
        expV[0] = 1'b1;  expV[1] = 1'b0;  expV[2] = 1'b1;
        HREADY = 1'b1;
        allIdle();
        HMASTER = 4'd1;
        tick();
        c0 = XFER_CNT;
        for (int i = 0; i < 3; i++) begin
            setMaster(1, seqT[i], 32'h0000_0100 + 32'(i * 4));
            tick();
            nCompared++;
            if (DVALID !== expV[i]) begin
                nMismatched++;
                $display("[TB] FAIL busy_dvalid step=%0d actual=%b required=%b", i, DVALID, expV[i]);
            end
        end
        allIdle();
        tick();
        tick();
        nCompared++;
        if (XFER_CNT !== c0 + 16'd2) begin
            nMismatched++;
            $display("[TB] FAIL busy_count actual=%0d required=%0d", XFER_CNT, c0 + 16'd2);
        end
    endtask

    task automatic test_lock();
        HMASTER = 4'd4;
        HMASTLOCK = 1'b1;
        setMaster(4, 2'b10, 32'h0000_4000);
        HREADY = 1'b0;
        tick();
        nCompared++;
        if (HMASTLOCK_D !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL lock_hold actual=%b required=0", HMASTLOCK_D);
        end
        HREADY = 1'b1;
        tick();
        nCompared++;
        if (HMASTLOCK_D !== 1'b1 || HMASTER_D !== 4'd4) begin
            nMismatched++;
            $display("[TB] FAIL lock_set actual=%b/%0d required=1/4", HMASTLOCK_D, HMASTER_D);
        end
        HMASTLOCK = 1'b0;
        allIdle();
        tick();
    endtask

    task automatic test_out_of_range();
        HREADY = 1'b1;
        for (int m = 0; m < NM; m++) setMaster(m, 2'b10, $urandom);
        HWRITEx = '1;
        HSIZEx  = '1;
        HBURSTx = '1;
        HMASTER = 4'd9;
        #1;
        nCompared++;
        if (HADDR !== '0 || HTRANS !== 2'b00 || HWRITE !== 1'b0 || HSIZE !== 3'd0 || HBURST !== 3'd0) begin
            nMismatched++;
            $display("[TB] FAIL oor_addr actual=%h/%b/%b/%0d/%0d required=0/00/0/0/0", HADDR, HTRANS, HWRITE, HSIZE, HBURST);
        end
        tick();
        nCompared++;
        if (DVALID !== 1'b0 || HMASTER_D !== 4'd9 || HWDATA !== '0) begin
            nMismatched++;
            $display("[TB] FAIL oor_data actual=%b/%0d/%h required=0/9/0", DVALID, HMASTER_D, HWDATA);
        end
        allIdle();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            HADDRx    = {NM{$urandom}};
            for (int m = 0; m < NM; m++) setMaster(m, 2'($urandom), $urandom);
            HWRITEx   = NM'($urandom);
            HSIZEx    = (NM*3)'({$urandom, $urandom});
            HBURSTx   = (NM*3)'({$urandom, $urandom});
            HMASTER   = 4'($urandom_range(0, 15));
            HMASTLOCK = 1'($urandom);
            HREADY    = ($urandom_range(0, 3) != 0);
            #1;
            nCompared++;
            if (HADDR !== addrOf(HMASTER) || HTRANS !== transOf(HMASTER) ||
                HWRITE !== ((HMASTER < NM) ? HWRITEx[HMASTER[2:0]] : 1'b0) ||
                HSIZE !== ((HMASTER < NM) ? HSIZEx[HMASTER[2:0]*3 +: 3] : 3'd0) ||
                HBURST !== ((HMASTER < NM) ? HBURSTx[HMASTER[2:0]*3 +: 3] : 3'd0)) begin
                nMismatched++;
                $display("[TB] FAIL rand_addr i=%0d master=%0d actual=%h/%b required=%h/%b",
                         i, HMASTER, HADDR, HTRANS, addrOf(HMASTER), transOf(HMASTER));
            end
            nCompared++;
            if (HMASTER_D !== mOwner || HMASTLOCK_D !== mLock || DVALID !== mValid ||
                XFER_CNT !== mCount || HWDATA !== expWdata()) begin
                nMismatched++;
                $display("[TB] FAIL rand_data i=%0d actual=%0d/%b/%b/%0d/%h required=%0d/%b/%b/%0d/%h",
                         i, HMASTER_D, HMASTLOCK_D, DVALID, XFER_CNT, HWDATA,
                         mOwner, mLock, mValid, mCount, expWdata());
            end
            tick();
        end
        HREADY = 1'b1;
        allIdle();
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        HREADY = 1'b1;
        HMASTER = 4'd6;
        setMaster(6, 2'b10, 32'h0000_6000);
        tick();
        setMaster(6, 2'b11, 32'h0000_6004);
        tick();
        nCompared++;
        if (DVALID !== 1'b1 || HMASTER_D !== 4'd6 || XFER_CNT === 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL areset_pre actual=%b/%0d/%0d required=1/6/nonzero", DVALID, HMASTER_D, XFER_CNT);
        end
        #2;
        HRESET = 1'b1;
        modelClear();
        #1;
        nCompared++;
        if (DVALID !== 1'b0 || HMASTER_D !== 4'd0 || XFER_CNT !== 16'd0 || HWDATA !== '0 || HTRANS !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL areset_clear actual=%b/%0d/%0d/%h/%b required=0/0/0/0/00",
                     DVALID, HMASTER_D, XFER_CNT, HWDATA, HTRANS);
        end
        tick();
        HRESET = 1'b0;
        tick();
        nCompared++;
        if (DVALID !== 1'b1 || HMASTER_D !== 4'd6 || XFER_CNT !== 16'd0) begin
            nMismatched++;
            $display("[TB] FAIL areset_first_edge actual=%b/%0d/%0d required=1/6/0", DVALID, HMASTER_D, XFER_CNT);
        end
    endtask

    task automatic test_wrap();
        int guard;
        HREADY = 1'b1;
        HMASTER = 4'd0;
        setMaster(0, 2'b11, 32'h0000_0000);
        guard = 0;
        while (mCount != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        nCompared++;
        if (XFER_CNT !== 16'hFFFF) begin
            nMismatched++;
            $display("[TB] FAIL wrap_preload actual=%h required=ffff", XFER_CNT);
        end
        tick();
        nCompared++;
        if (XFER_CNT !== 16'h0000) begin
            nMismatched++;
            $display("[TB] FAIL wrap_zero actual=%h required=0000", XFER_CNT);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        HRESET    = 1'b1;
        HMASTER   = 4'd0;
        HMASTLOCK = 1'b0;
        HREADY    = 1'b1;
        HADDRx    = '0;
        HTRANSx   = '0;
        HWRITEx   = '0;
        HSIZEx    = '0;
        HBURSTx   = '0;
        HWDATAx   = '0;
        modelClear();
        @(posedge HCLK);
        #1;
        test_reset();
        test_handover();
        test_wait_states();
        test_busy_filter();
        test_lock();
        test_out_of_range();
        test_random();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
